// File: rtl/mmm_serial.sv
// Bit-serial Montgomery multiplier: p_out = A*B*2^-WIDTH mod M, one radix-2 step per enabled edge.
// Latency: done/p_out valid WIDTH+1 enabled edges after the ld_a edge; ena=0 freezes all state.
module mmm_serial #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             clear,
    input  logic             ld_a,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [WIDTH-1:0] m_in,
    output logic [WIDTH-1:0] p_out,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int RW = WIDTH + 2;

    typedef enum logic [1:0] {IDLE, RUN, SUB, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] m_q;
    logic [WIDTH-1:0] p_q;
    logic [RW-1:0]    r_q;
    logic [CW-1:0]    cnt_q;
    logic             done_q;

    logic [RW-1:0]    sum_ab;
    logic [RW-1:0]    sum_abm;
    logic [RW-1:0]    r_d;
    logic [RW-1:0]    r_sub;
    logic [WIDTH-1:0] p_d;
    logic             q_bit;

    // R stays below 2M, so R + B + M < 4M fits in WIDTH+2 bits
    always_comb begin
        sum_ab  = r_q + (a_q[0] ? RW'(b_q) : '0);
        q_bit   = sum_ab[0];
        sum_abm = sum_ab + (q_bit ? RW'(m_q) : '0);
        r_d     = sum_abm >> 1;
        r_sub   = r_q - RW'(m_q);
        p_d     = (r_q >= RW'(m_q)) ? r_sub[WIDTH-1:0] : r_q[WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            m_q     <= '0;
            p_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else if (ena) begin
            if (!clear) begin
                state_q <= IDLE;
                r_q     <= '0;
                p_q     <= '0;
                cnt_q   <= '0;
                done_q  <= 1'b0;
            end else if (ld_a) begin
                a_q     <= a_in;
                b_q     <= b_in;
                m_q     <= m_in;
                r_q     <= '0;
                cnt_q   <= '0;
                done_q  <= 1'b0;
                state_q <= RUN;
            end else begin
                case (state_q)
                    IDLE: done_q <= 1'b0;
                    RUN: begin
                        r_q   <= r_d;
                        a_q   <= a_q >> 1;
                        cnt_q <= cnt_q + CW'(1);
                        if (cnt_q == CW'(WIDTH - 1)) begin
                            state_q <= SUB;
                        end
                    end
                    SUB: begin
                        p_q     <= p_d;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                    DONE: done_q <= 1'b1;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign p_out = p_q;
    assign done  = done_q;

endmodule

// File: tb/tb_mmm_serial.sv
// Bench for mmm_serial: 8- and 16-bit instances run in lockstep against a latency/arithmetic reference model.
module tb_mmm_serial;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ena = 1'b1;
    logic        clear = 1'b1;
    logic        ld_a = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0, m8 = '0, p8;
    logic [15:0] a16 = '0, b16 = '0, m16 = '0, p16;
    logic        done8, done16;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mmm_serial #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .ena(ena), .clear(clear), .ld_a(ld_a),
        .a_in(a8), .b_in(b8), .m_in(m8), .p_out(p8), .done(done8)
    );

    mmm_serial #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .ena(ena), .clear(clear), .ld_a(ld_a),
        .a_in(a16), .b_in(b16), .m_in(m16), .p_out(p16), .done(done16)
    );

    // A*B*2^-w mod M, using 2^-1 = (M+1)/2 for odd M
    function automatic longint mont_ref(input longint a, input longint b, input longint m, input int w);
        longint x;
        longint inv2;
        x    = (a * b) % m;
        inv2 = (m + 1) / 2;
        for (int i = 0; i < w; i++) x = (x * inv2) % m;
        return x;
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: result appears WIDTH+1 enabled edges after the ld_a edge
    int     cd8 = 0, cd16 = 0;
    bit     ed8 = 0, ed16 = 0;
    longint ep8 = 0, ep16 = 0, pend8 = 0, pend16 = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cd8 = 0; cd16 = 0; ed8 = 0; ed16 = 0; ep8 = 0; ep16 = 0;
        end else if (ena) begin
            if (!clear) begin
                cd8 = 0; cd16 = 0; ed8 = 0; ed16 = 0; ep8 = 0; ep16 = 0;
            end else if (ld_a) begin
                cd8    = 9;
                cd16   = 17;
                ed8    = 0;
                ed16   = 0;
                pend8  = mont_ref(longint'(a8), longint'(b8), longint'(m8), 8);
                pend16 = mont_ref(longint'(a16), longint'(b16), longint'(m16), 16);
            end else begin
                if (cd8 > 0) begin
                    cd8--;
                    if (cd8 == 0) begin ed8 = 1; ep8 = pend8; end
                end
                if (cd16 > 0) begin
                    cd16--;
                    if (cd16 == 0) begin ed16 = 1; ep16 = pend16; end
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("model_done8", longint'(done8), longint'(ed8));
        chk("model_p8", longint'(p8), ep8);
        chk("model_done16", longint'(done16), longint'(ed16));
        chk("model_p16", longint'(p16), ep16);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input int a, input int b, input int m);
        ena = 1'b1; clear = 1'b1; ld_a = 1'b1;
        a8 = 8'(a); b8 = 8'(b); m8 = 8'(m);
        a16 = 16'(a); b16 = 16'(b); m16 = 16'(m);
        step();
        ld_a = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); m8 = 8'($urandom);
        a16 = 16'($urandom); b16 = 16'($urandom); m16 = 16'($urandom);
    endtask

    task automatic wait_check(input int exp_p, input bit stall, input string nm);
        int n;
        bit got;
        n = 0;
        got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            ena = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            step();
            if (ena) n++;
            if (done8) got = 1;
        end
        ena = 1'b1;
        chk({nm, "_done"}, longint'(got), 1);
        chk({nm, "_latency"}, longint'(n), 9);
        chk({nm, "_p"}, longint'(p8), longint'(exp_p));
        for (int i = 0; i < 40 && !done16; i++) step();
        chk({nm, "_done16"}, longint'(done16), 1);
    endtask

    task automatic run_lit(input int a, input int b, input int m, input int exp_p,
                           input bit stall, input string nm);
        start_op(a, b, m);
        wait_check(exp_p, stall, nm);
    endtask

    initial begin
        chk("ref_basic", mont_ref(5, 7, 239, 8), 227);
        chk("ref_sub", mont_ref(238, 238, 239, 8), 225);
        chk("ref_m255", mont_ref(1, 1, 255, 8), 1);

        #1 rst = 1'b1;
        #2;
        chk("rst_p8", longint'(p8), 0);
        chk("rst_done8", longint'(done8), 0);
        chk("rst_p16", longint'(p16), 0);
        chk("rst_done16", longint'(done16), 0);
        step();
        step();
        rst = 1'b0;
        repeat (3) step();
        chk("idle_no_start", longint'(done8), 0);

        run_lit(5, 7, 239, 227, 1'b0, "basic");
        run_lit(238, 238, 239, 225, 1'b0, "sub_path");
        run_lit(1, 1, 255, 1, 1'b0, "m255");
        run_lit(0, 200, 239, 0, 1'b0, "a_zero");
        run_lit(5, 7, 239, 227, 1'b1, "ena_stall");

        start_op(5, 7, 239);
        repeat (3) step();
        start_op(238, 238, 239);
        wait_check(225, 1'b0, "restart");

        clear = 1'b0;
        step();
        clear = 1'b1;
        chk("clear_done", longint'(done8), 0);
        chk("clear_p", longint'(p8), 0);

        run_lit(238, 238, 239, 225, 1'b0, "pre_rst");
        start_op(5, 7, 239);
        repeat (3) step();
        #2 rst = 1'b1;
        #1;
        chk("rst_run_p8", longint'(p8), 0);
        chk("rst_run_done8", longint'(done8), 0);
        chk("rst_run_p16", longint'(p16), 0);
        step();
        rst = 1'b0;
        repeat (20) step();
        chk("rst_abandon", longint'(done8), 0);

        for (int k = 0; k < 1000; k++) begin
            int mm8, mm16;
            bit fin;
            mm8  = $urandom_range(1, 127) * 2 + 1;
            mm16 = $urandom_range(1, 32767) * 2 + 1;
            ena = 1'b1; ld_a = 1'b1;
            m8  = 8'(mm8);  a8  = 8'($urandom_range(0, mm8 - 1));  b8  = 8'($urandom_range(0, mm8 - 1));
            m16 = 16'(mm16); a16 = 16'($urandom_range(0, mm16 - 1)); b16 = 16'($urandom_range(0, mm16 - 1));
            step();
            ld_a = 1'b0;
            a8 = 8'($urandom); a16 = 16'($urandom);
            fin = 0;
            for (int i = 0; i < 100 && !fin; i++) begin
                ena = ($urandom_range(0, 3) != 0);
                step();
                fin = done8 && done16;
            end
            ena = 1'b1;
            chk("rand_done", longint'(fin), 1);
        end

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mmm_serial.md
MMM_SERIAL -- requirements
Module: mmm_serial

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the operand and result width in bits.
REQ-002 The port clk SHALL be an input, 1 bit wide, and be the single clock; all state SHALL update on its rising edge.
REQ-003 The port rst SHALL be an input, 1 bit wide, and be the reset: asynchronous, active-high.
REQ-004 The port ena SHALL be an input, 1 bit wide; it is the global clock enable, and all state SHALL hold while it is 0.
REQ-005 The port clear SHALL be an input, 1 bit wide; it is a synchronous active-low clear, driven by the control unit's clear_mmm.
REQ-006 The port ld_a SHALL be an input, 1 bit wide; a 1 captures the operands and starts a multiplication.
REQ-007 The port a_in SHALL be an input, WIDTH bits wide, carrying operand A; precondition A < M.
REQ-008 The port b_in SHALL be an input, WIDTH bits wide, carrying operand B; precondition B < M.
REQ-009 The port m_in SHALL be an input, WIDTH bits wide, carrying modulus M; precondition M is odd and M > 1.
REQ-010 The port p_out SHALL be an output, WIDTH bits wide, carrying the result A*B*2^-WIDTH mod M.
REQ-011 The port done SHALL be an output, 1 bit wide; a 1 means p_out holds a valid result.

Function
REQ-012 The module SHALL implement a four-state FSM: IDLE, RUN, SUB, DONE.
REQ-013 Every rule below SHALL apply only on edges where ena=1; with ena=0 the FSM, all registers and all outputs SHALL hold.
REQ-014 Priority on an enabled edge SHALL be: clear=0 first, then ld_a=1, then the normal transition.
REQ-015 clear=0 SHALL force IDLE, zero the accumulator, p_out and the bit counter, and drive done=0, in any state.
REQ-016 ld_a=1 with clear=1 SHALL, in any state (including RUN and DONE), restart the operation:
  - capture a_in into the A shift register, and b_in and m_in into holding registers;
  - zero the accumulator R (WIDTH+2 bits) and the bit counter, and drive done=0;
  - go to RUN.
REQ-017 RUN SHALL perform one radix-2 step per edge, for WIDTH edges, with a = A shift register bit 0:
  - q = (R + a*B) bit 0;
  - R <= (R + a*B + q*M) >> 1;
  - A shifts right one bit;
  - the counter increments.
REQ-018 RUN SHALL go to SUB on the edge where the counter equals WIDTH-1.
REQ-019 SUB SHALL, in one edge:
  - load p_out with R-M if R >= M, else with R, truncated to WIDTH bits;
  - set done=1;
  - go to DONE.
REQ-020 DONE SHALL hold p_out and done=1 until clear=0 or ld_a=1; IDLE SHALL hold done=0.
REQ-021 Internal sums SHALL be WIDTH+2 bits wide so that R + B + M (< 4M) never overflows, and R SHALL stay below 2M after every step.
REQ-022 Latency: with ld_a sampled at enabled edge k, done and p_out SHALL be valid after enabled edge k+WIDTH+1, matching a control unit that counts WIDTH+1 step cycles after its ld_a cycle and loads the result on the next cycle.
REQ-023 Operands SHALL be sampled only on the ld_a edge; changes to a_in, b_in or m_in afterwards SHALL NOT affect the running operation.
REQ-024 With M even, or an operand >= M, p_out SHALL be unspecified, but the FSM SHALL still reach DONE at the latency of REQ-022.
REQ-025 p_out and done SHALL be driven directly from registers, with no combinational path from any input.

Reset
REQ-026 While rst=1, regardless of clk and ena, the module SHALL be in IDLE with p_out=0, done=0, R=0, counter=0 and all operand registers 0.
REQ-027 After rst falls, no operation SHALL start until ld_a=1 is sampled with ena=1 and clear=1.
REQ-028 If rst is asserted mid-RUN, the module SHALL abandon the operation, and done SHALL NOT assert for it.

Verification
REQ-029 Basic multiply: WIDTH=8, M=239, A=5, B=7, single ld_a pulse -> done=1 exactly 9 enabled edges after the ld_a edge, with p_out=227.
REQ-030 Final-subtract path: M=239, A=238, B=238 -> p_out=225; M=255, A=1, B=1 -> p_out=1; A=0, B=200, M=239 -> p_out=0.
REQ-031 ena stalls: ena toggled pseudo-randomly during the M=239, A=5, B=7 run -> same p_out=227, and done arrives after exactly 9 enabled edges.
REQ-032 Restart mid-RUN: ld_a re-pulsed at RUN step 4 with A=238, B=238, M=239 -> first operation discarded; done 9 edges after the second pulse with p_out=225.
REQ-033 Clear and reset: clear=0 in DONE -> done=0 and p_out=0 on the next edge; rst pulsed mid-RUN -> outputs 0 immediately, and done stays 0.
REQ-034 Randomized check: 1000 random odd M with A, B < M, for WIDTH=8 and WIDTH=16 -> p_out matches the reference-model value A*B*inv(2^WIDTH) mod M every time.
